// File: rtl/pled_sequencer_if.sv
// Control and status bundle of the LED pattern sequencer.
// The master side drives mode, dir, step and duty; the slave side returns the LED drive and status.
interface pled_sequencer_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
);
    logic [1:0]          mode;
    logic                dir;
    logic                step;
    logic [PWM_BITS-1:0] duty;
    logic [CHANNELS-1:0] led_out;
    logic                tick;
    logic [CHANNELS-1:0] pattern;

    modport master (
        output mode, dir, step, duty,
        input  led_out, tick, pattern
    );

    modport slave (
        input  mode, dir, step, duty,
        output led_out, tick, pattern
    );
endinterface

// File: rtl/pled_sequencer.sv
// LED pattern sequencer: a prescaled tick drives rotate/bounce/hold/off patterns.
// The LED outputs are PWM-gated for brightness control.
module pled_sequencer #(
    parameter int                  CHANNELS     = 3,
    parameter int                  PRESCALE     = 10000,
    parameter int                  PWM_BITS     = 8,
    parameter logic [CHANNELS-1:0] INIT_PATTERN = {{(CHANNELS-1){1'b1}}, 1'b0}
) (
    input logic             sys_clk,
    input logic             reset_n,
    pled_sequencer_if.slave bus
);
    localparam int                 PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_BITS-1:0] PS_LAST = PS_BITS'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    logic [PS_BITS-1:0]  ps_cnt;
    logic [PS_BITS-1:0]  ps_next;
    logic                tick_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                gate;
    logic [2:0]          step_sync;
    logic                step_edge;
    mode_t               mode_q;
    mode_t               next_mode;
    logic [CHANNELS-1:0] pattern_q;
    logic [CHANNELS-1:0] next_pattern;
    logic                bounce_up;
    logic                next_bounce_up;
    logic [CHANNELS-1:0] led_q;

    function automatic logic [CHANNELS-1:0] rotate(input logic [CHANNELS-1:0] p, input logic d);
        return d ? {p[0], p[CHANNELS-1:1]} : {p[CHANNELS-2:0], p[CHANNELS-1]};
    endfunction

    // The tick is registered but looks ahead one count, so it is high exactly while ps_cnt is at its last value.
    assign ps_next   = (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_BITS'(1);
    assign gate      = (&bus.duty) | (pwm_cnt < bus.duty);
    assign step_edge = step_sync[1] & ~step_sync[2];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt    <= '0;
            tick_q    <= 1'b0;
            pwm_cnt   <= '0;
            step_sync <= '0;
        end else begin
            ps_cnt    <= ps_next;
            tick_q    <= (ps_next == PS_LAST);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            step_sync <= {step_sync[1:0], bus.step};
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_ROTATE;
            pattern_q <= INIT_PATTERN;
            bounce_up <= 1'b1;
            led_q     <= '0;
        end else begin
            mode_q    <= next_mode;
            pattern_q <= next_pattern;
            bounce_up <= next_bounce_up;
            led_q     <= (mode_q == MODE_OFF) ? '0 : (pattern_q & {CHANNELS{gate}});
        end
    end

    // The mode input only matters on a tick; between ticks only a HOLD step edge can move the pattern.
    always_comb begin
        next_mode      = mode_q;
        next_pattern   = pattern_q;
        next_bounce_up = bounce_up;
        if (tick_q) begin
            next_mode = mode_t'(bus.mode);
            unique case (next_mode)
                MODE_ROTATE: begin
                    if (pattern_q == '0) begin
                        next_pattern = INIT_PATTERN;
                    end else begin
                        next_pattern = rotate(pattern_q, bus.dir);
                    end
                end
                MODE_BOUNCE: begin
                    if (mode_q != MODE_BOUNCE) begin
                        next_pattern   = CHANNELS'(1);
                        next_bounce_up = 1'b1;
                    end else if (bounce_up) begin
                        if (pattern_q[CHANNELS-1]) begin
                            next_pattern   = pattern_q >> 1;
                            next_bounce_up = 1'b0;
                        end else begin
                            next_pattern = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            next_pattern   = pattern_q << 1;
                            next_bounce_up = 1'b1;
                        end else begin
                            next_pattern = pattern_q >> 1;
                        end
                    end
                end
                MODE_HOLD: begin
                    if (step_edge) begin
                        next_pattern = rotate(pattern_q, bus.dir);
                    end
                end
                MODE_OFF: begin
                    next_pattern = pattern_q;
                end
            endcase
        end else if ((mode_q == MODE_HOLD) && step_edge) begin
            next_pattern = rotate(pattern_q, bus.dir);
        end
    end

    assign bus.tick    = tick_q;
    assign bus.pattern = pattern_q;
    assign bus.led_out = led_q;
endmodule

// File: tb/tb_pled_sequencer.sv
// Bench for pled_sequencer: directed scenarios plus a randomized run, all compared
// every cycle against an arithmetic reference model of the sequencer behaviour.
module tb_pled_sequencer;
    localparam int          N    = 3;
    localparam int          P    = 4;
    localparam int          W    = 4;
    localparam logic [N-1:0] INIT = 3'b110;

    logic sys_clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    pled_sequencer_if #(.CHANNELS(N), .PWM_BITS(W)) bus ();

    pled_sequencer #(.CHANNELS(N), .PRESCALE(P), .PWM_BITS(W)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic d, input logic [W-1:0] dt);
        bus.mode = m;
        bus.dir  = d;
        bus.duty = dt;
    endtask

    task automatic cycles(input int c);
        repeat (c) @(negedge sys_clk);
    endtask

    function automatic logic [N-1:0] rot(input logic [N-1:0] p, input logic d);
        int v;
        v = int'(p);
        if (!d) v = (v * 2 + v / (2 ** (N - 1))) % (2 ** N);
        else    v = v / 2 + (v % 2) * (2 ** (N - 1));
        return N'(v);
    endfunction

    // Reference model: n counts rising edges since reset release; positions and step history are plain integers.
    int           n;
    int           m_mode_q;
    int           m_mode_in;
    int           m_pos;
    bit           m_up;
    bit           tick_now;
    bit           edge_now;
    bit           gate_now;
    bit           sh[$];
    logic [N-1:0] m_pat;
    logic [N-1:0] m_led;
    logic         m_tick;

    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            n        = 0;
            m_mode_q = 0;
            m_pos    = 0;
            m_up     = 1'b1;
            m_pat    = INIT;
            m_led    = '0;
            m_tick   = 1'b0;
            sh       = '{1'b0, 1'b0, 1'b0};
        end else begin
            tick_now = ((n % P) == P - 1);
            edge_now = sh[1] && !sh[2];
            gate_now = (bus.duty == 4'hF) || ((n % 16) < int'(bus.duty));
            m_led    = (m_mode_q == 3) ? '0 : (gate_now ? m_pat : '0);
            if (tick_now) begin
                m_mode_in = int'(bus.mode);
                case (m_mode_in)
                    0: m_pat = (m_pat == '0) ? INIT : rot(m_pat, bus.dir);
                    1: begin
                        if (m_mode_q != 1) begin
                            m_pos = 0;
                            m_up  = 1'b1;
                        end else if (m_up) begin
                            if (m_pos == N - 1) begin m_up = 1'b0; m_pos--; end
                            else m_pos++;
                        end else begin
                            if (m_pos == 0) begin m_up = 1'b1; m_pos++; end
                            else m_pos--;
                        end
                        m_pat = N'(1 << m_pos);
                    end
                    2: if (edge_now) m_pat = rot(m_pat, bus.dir);
                    default: ;
                endcase
                m_mode_q = m_mode_in;
            end else if (m_mode_q == 2 && edge_now) begin
                m_pat = rot(m_pat, bus.dir);
            end
            sh.push_front(bus.step);
            void'(sh.pop_back());
            n++;
            m_tick = ((n % P) == P - 1);
        end
    end

    always @(negedge sys_clk) begin
        check_output("tick", 32'(bus.tick), 32'(m_tick));
        check_output("pattern", 32'(bus.pattern), 32'(m_pat));
        check_output("led_out", 32'(bus.led_out), 32'(m_led));
    end

    logic [N-1:0] bounce_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
    int hi_cnt;
    int odd_cnt;

    initial begin
        reset_n  = 1'b0;
        bus.step = 1'b0;
        apply_stimulus(2'd0, 1'b0, 4'hF);
        cycles(3);
        check_output("reset_pattern", 32'(bus.pattern), 32'(INIT));
        check_output("reset_led", 32'(bus.led_out), 32'd0);
        check_output("reset_tick", 32'(bus.tick), 32'd0);

        $display("[TB] rotate after release");
        reset_n = 1'b1;
        cycles(3);
        check_output("first_tick", 32'(bus.tick), 32'd1);
        check_output("rot_hold_110", 32'(bus.pattern), 32'b110);
        cycles(1);
        check_output("rot_101", 32'(bus.pattern), 32'b101);
        check_output("tick_low", 32'(bus.tick), 32'd0);
        cycles(1);
        check_output("led_follows", 32'(bus.led_out), 32'b101);
        cycles(3);
        check_output("rot_011", 32'(bus.pattern), 32'b011);
        cycles(4);
        check_output("rot_110", 32'(bus.pattern), 32'b110);

        $display("[TB] bounce");
        apply_stimulus(2'd1, 1'b0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            cycles(4);
            check_output("bounce", 32'(bus.pattern), 32'(bounce_exp[i]));
        end

        $display("[TB] async reset mid-rotation");
        apply_stimulus(2'd0, 1'b0, 4'hF);
        cycles(5);
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_pattern", 32'(bus.pattern), 32'(INIT));
        check_output("async_led", 32'(bus.led_out), 32'd0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        apply_stimulus(2'd2, 1'b1, 4'hF);
        cycles(2);
        check_output("post_reset_no_tick", 32'(bus.tick), 32'd0);
        cycles(1);
        check_output("post_reset_tick", 32'(bus.tick), 32'd1);

        $display("[TB] hold with step over a tick");
        cycles(2);
        check_output("hold_ignores_tick", 32'(bus.pattern), 32'b110);
        bus.step = 1'b1;
        cycles(5);
        check_output("hold_step_once", 32'(bus.pattern), 32'b011);
        cycles(45);
        bus.step = 1'b0;
        cycles(9);
        check_output("hold_stays", 32'(bus.pattern), 32'b011);

        $display("[TB] off and resume");
        apply_stimulus(2'd3, 1'b1, 4'hF);
        cycles(6);
        check_output("off_led", 32'(bus.led_out), 32'd0);
        check_output("off_pattern", 32'(bus.pattern), 32'b011);
        bus.step = 1'b1;
        cycles(6);
        bus.step = 1'b0;
        cycles(4);
        check_output("off_step_ignored", 32'(bus.pattern), 32'b011);
        apply_stimulus(2'd0, 1'b0, 4'hF);
        cycles(4);
        check_output("resume_rot", 32'(bus.pattern), 32'b110);
        cycles(1);
        check_output("resume_led", 32'(bus.led_out), 32'b110);

        $display("[TB] pwm duty");
        apply_stimulus(2'd2, 1'b0, 4'hF);
        cycles(3);
        bus.duty = 4'd4;
        cycles(2);
        hi_cnt = 0; odd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            if (bus.led_out == 3'b110) hi_cnt++;
            else if (bus.led_out != 3'b000) odd_cnt++;
        end
        check_output("duty4_high", 32'(hi_cnt), 32'd8);
        check_output("duty4_shape", 32'(odd_cnt), 32'd0);
        bus.duty = 4'd0;
        cycles(2);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            if (bus.led_out != 3'b000) hi_cnt++;
        end
        check_output("duty0_off", 32'(hi_cnt), 32'd0);
        bus.duty = 4'hF;
        cycles(2);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            if (bus.led_out == 3'b110) hi_cnt++;
        end
        check_output("duty15_on", 32'(hi_cnt), 32'd16);

        $display("[TB] randomized run");
        for (int i = 0; i < 800; i++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) bus.duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.step = ~bus.step;
        end
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pled_sequencer.md
PLED_SEQUENCER -- requirements
Module: pled_sequencer

Interface
REQ-001 Parameter CHANNELS, default 3: number of LED drive outputs, legal range 2..16.
REQ-002 Parameter PRESCALE, default 10000: sys_clk cycles per sequencer tick, legal range >= 2.
REQ-003 Parameter PWM_BITS, default 8: width of the brightness duty word and PWM counter.
REQ-004 Parameter INIT_PATTERN, default CHANNELS'b110 (bit0 clear, all other bits set): pattern loaded at reset.
REQ-005 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 mode  input  2  0=ROTATE, 1=BOUNCE, 2=HOLD, 3=OFF.
REQ-008 dir  input  1  0=shift toward MSB, 1=shift toward LSB (ROTATE and HOLD only).
REQ-009 step  input  1  asynchronous push-button level; a rising edge advances the pattern in HOLD.
REQ-010 duty  input  PWM_BITS  brightness; all-ones means fully on, zero means fully off.
REQ-011 led_out  output  CHANNELS  registered PWM-gated drive, one bit per channel.
REQ-012 tick  output  1  one-cycle pulse on each sequencer tick.
REQ-013 pattern  output  CHANNELS  current unmodulated pattern register.

Function
REQ-014 Prescaler: counter 0..PRESCALE-1, increments every cycle, wraps to 0; tick=1 in the cycle the counter equals PRESCALE-1, else 0; no derived clocks.
REQ-015 mode is sampled only on tick; mode changes take effect at the next tick, never mid-period.
REQ-016 ROTATE: on tick, pattern rotates by one position (dir=0: {p[N-2:0],p[N-1]}; dir=1: {p[0],p[N-1:1]}).
REQ-017 ROTATE entry with pattern==0 loads INIT_PATTERN on that tick instead of rotating.
REQ-018 BOUNCE: pattern is one-hot; a 1-bit bounce-direction register moves the hot bit up or down by one per tick and reverses direction at bit CHANNELS-1 and at bit 0.
REQ-019 BOUNCE entry (previous sampled mode not BOUNCE) loads pattern=1 and bounce direction=up on that tick.
REQ-020 HOLD: pattern changes only on a detected step edge, rotating one position per dir exactly as in ROTATE; ticks are ignored.
REQ-021 step path: 2-flop synchroniser plus edge detector; one synchronised rising edge yields exactly one advance; step is ignored outside HOLD.
REQ-022 OFF: pattern retained unchanged; led_out forced to 0.
REQ-023 PWM: free-running PWM_BITS counter increments every cycle and wraps; gate=1 when duty is all-ones, else gate=(pwm_cnt < duty).
REQ-024 led_out is registered as pattern & {CHANNELS{gate}}, or 0 in OFF, giving one cycle latency from pattern/gate to led_out.
REQ-025 A step edge coinciding with a tick in HOLD produces exactly one advance.
REQ-026 duty changes take effect on the next cycle with no glitch beyond one PWM period.

Reset
REQ-027 On reset_n low, asynchronously: prescaler=0, pwm_cnt=0, tick=0, led_out=0, pattern=INIT_PATTERN, bounce direction=up, sampled mode=ROTATE, synchroniser and edge flops=0.
REQ-028 Reset asserted mid-sequence discards all state; the first tick after release occurs PRESCALE cycles after release.

Verification
REQ-029 CHANNELS=3, PRESCALE=4, mode=0, dir=0, duty=all-ones, reset release -> tick every 4th cycle; pattern 110 -> 101 -> 011 -> 110; led_out equals pattern one cycle later.
REQ-030 CHANNELS=4, mode=1 for 8 ticks -> pattern 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-031 PWM_BITS=4, duty=4, pattern=111 -> led_out high 4 of every 16 cycles; duty=0 -> always 0; duty=15 -> always 111.
REQ-032 mode=2, dir=1, one 50-cycle step pulse overlapping a tick -> pattern advances exactly once, 110 -> 011; no change on later ticks.
REQ-033 mode=3 -> led_out=0 from the first tick after the change; return to mode=0 -> rotation resumes from the retained pattern.
REQ-034 reset_n pulsed low mid-rotation -> led_out=0 and pattern=INIT_PATTERN immediately, without waiting for a clock edge; the first tick follows 4 cycles after release.
